// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - single-transaction vending controller with per-item stock
//
// Evaluates one purchase request per req edge against the packed price table,
// the internal stock counters and the inserted money; dispenses with change or
// rejects with a full refund. All outputs are registered.
//
// Ports:
//   clk         in   1  clock, rising edge
//   rst_n       in   1  synchronous active-low reset
//   req         in   1  request strobe, sampled on each rising edge
//   code        in   2  item select 0..3
//   count       in   3  requested quantity 0..7
//   temp        in   8  packed price table, item k field temp[2k+1:2k], price = field + 1
//   money       in   4  inserted money 0..15
//   posibility  out  1  1 = last transaction accepted
//   remaining   out  4  change (accept) or refund (reject) of the last transaction
module vending_machine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] code,
    input  logic [2:0] count,
    input  logic [7:0] temp,
    input  logic [3:0] money,
    output logic       posibility,
    output logic [3:0] remaining
);

    logic       posibility_q, posibility_d;
    logic [3:0] remaining_q, remaining_d;
    logic [2:0] stock_q [4];
    logic [2:0] stock_d [4];

    logic [1:0] price_field;
    logic [2:0] price;
    logic [4:0] cost;
    logic [2:0] cur_stock;
    logic       accept;

    always_comb begin
        price_field = temp[{code, 1'b0} +: 2];
        price       = {1'b0, price_field} + 3'd1;
        // 5-bit product: max 4 * 7 = 28, so no truncation
        cost        = {2'b00, price} * {2'b00, count};
        cur_stock   = stock_q[code];
        accept      = (count != 3'd0) && (count <= cur_stock) && ({1'b0, money} >= cost);

        posibility_d = posibility_q;
        remaining_d  = remaining_q;
        for (int i = 0; i < 4; i++) begin
            stock_d[i] = stock_q[i];
        end

        if (req) begin
            if (accept) begin
                posibility_d  = 1'b1;
                // cost <= money <= 15 here, so the low 4 bits carry the full value
                remaining_d   = money - cost[3:0];
                stock_d[code] = cur_stock - count;
            end else begin
                posibility_d = 1'b0;
                remaining_d  = money;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            posibility_q <= 1'b0;
            remaining_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= 3'd7;
            end
        end else begin
            posibility_q <= posibility_d;
            remaining_q  <= remaining_d;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign posibility = posibility_q;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - directed self-checking bench for vending_machine
module tb_vending_machine;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] code;
    logic [2:0] count;
    logic [7:0] temp;
    logic [3:0] money;
    logic       posibility;
    logic [3:0] remaining;

    int checks;
    int passed;

    vending_machine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .code       (code),
        .count      (count),
        .temp       (temp),
        .money      (money),
        .posibility (posibility),
        .remaining  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [1:0] c, input logic [2:0] n,
                         input logic [7:0] t, input logic [3:0] m);
        req = r; code = c; count = n; temp = t; money = m;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 8'h00, 4'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 3'd1, 8'hFF, 4'd15);
        drive(1'b1, 2'd1, 3'd3, 8'h5A, 4'd12);
        checks++; if (posibility !== 1'b0) $display("FAIL reset_pos: got %0b expected 0", posibility); else passed++;
        checks++; if (remaining !== 4'd0) $display("FAIL reset_rem: got %0d expected 0", remaining); else passed++;
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 3'd7, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b1) $display("FAIL reset_full_stock_pos: got %0b expected 1", posibility); else passed++;
        checks++; if (remaining !== 4'd8) $display("FAIL reset_full_stock_rem: got %0d expected 8", remaining); else passed++;
        req = 1'b0;
    endtask

    task automatic test_basic_accept();
        drive(1'b1, 2'd0, 3'd1, 8'b00111001, 4'd7);
        checks++; if (posibility !== 1'b1) $display("FAIL basic_pos: got %0b expected 1", posibility); else passed++;
        checks++; if (remaining !== 4'd5) $display("FAIL basic_rem: got %0d expected 5", remaining); else passed++;
        // stock[0] is now 6: asking for 7 must fail, 6 must succeed (price 1 with temp 0)
        drive(1'b1, 2'd0, 3'd7, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b0) $display("FAIL basic_stock6_over_pos: got %0b expected 0", posibility); else passed++;
        drive(1'b1, 2'd0, 3'd6, 8'h00, 4'd15);
        checks++; if (remaining !== 4'd9 || posibility !== 1'b1) $display("FAIL basic_stock6_exact: got pos=%0b rem=%0d expected pos=1 rem=9", posibility, remaining); else passed++;
        req = 1'b0;
    endtask

    task automatic test_insufficient_money();
        drive(1'b1, 2'd2, 3'd2, 8'b00111001, 4'd7);
        checks++; if (posibility !== 1'b0) $display("FAIL short_money_pos: got %0b expected 0", posibility); else passed++;
        checks++; if (remaining !== 4'd7) $display("FAIL short_money_rem: got %0d expected 7", remaining); else passed++;
        drive(1'b1, 2'd2, 3'd2, 8'b00111001, 4'd8);
        checks++; if (posibility !== 1'b1) $display("FAIL exact_money_pos: got %0b expected 1", posibility); else passed++;
        checks++; if (remaining !== 4'd0) $display("FAIL exact_money_rem: got %0d expected 0", remaining); else passed++;
        req = 1'b0;
    endtask

    task automatic test_zero_quantity();
        drive(1'b1, 2'd1, 3'd0, 8'b00111001, 4'd9);
        checks++; if (posibility !== 1'b0) $display("FAIL zero_qty_pos: got %0b expected 0", posibility); else passed++;
        checks++; if (remaining !== 4'd9) $display("FAIL zero_qty_rem: got %0d expected 9", remaining); else passed++;
        // stock[1] still 7
        drive(1'b1, 2'd1, 3'd7, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd8) $display("FAIL zero_qty_stock: got pos=%0b rem=%0d expected pos=1 rem=8", posibility, remaining); else passed++;
        req = 1'b0;
    endtask

    task automatic test_hold();
        drive(1'b1, 2'd2, 3'd1, 8'b00111001, 4'd11);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd7) $display("FAIL hold_setup: got pos=%0b rem=%0d expected pos=1 rem=7", posibility, remaining); else passed++;
        drive(1'b0, 2'd0, 3'd0, 8'hFF, 4'd2);
        drive(1'b0, 2'd3, 3'd5, 8'h12, 4'd13);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd7) $display("FAIL hold_idle: got pos=%0b rem=%0d expected pos=1 rem=7", posibility, remaining); else passed++;
    endtask

    task automatic test_stock_exhaustion();
        pulse_reset();
        drive(1'b1, 2'd3, 3'd7, 8'b00111001, 4'd15);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd8) $display("FAIL exhaust_take_all: got pos=%0b rem=%0d expected pos=1 rem=8", posibility, remaining); else passed++;
        drive(1'b1, 2'd3, 3'd1, 8'b00111001, 4'd15);
        checks++; if (posibility !== 1'b0) $display("FAIL exhaust_empty_pos: got %0b expected 0", posibility); else passed++;
        checks++; if (remaining !== 4'd15) $display("FAIL exhaust_empty_rem: got %0d expected 15", remaining); else passed++;
        drive(1'b1, 2'd0, 3'd1, 8'b00111001, 4'd7);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd5) $display("FAIL exhaust_other_item: got pos=%0b rem=%0d expected pos=1 rem=5", posibility, remaining); else passed++;
        req = 1'b0;
    endtask

    task automatic test_mid_reset();
        // item 3 is empty here; reset with a simultaneous req discards that req
        rst_n = 1'b0;
        drive(1'b1, 2'd3, 3'd1, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b0 || remaining !== 4'd0) $display("FAIL midreset_out: got pos=%0b rem=%0d expected pos=0 rem=0", posibility, remaining); else passed++;
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 3'd7, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd8) $display("FAIL midreset_restock: got pos=%0b rem=%0d expected pos=1 rem=8", posibility, remaining); else passed++;
        req = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        drive(1'b1, 2'd0, 3'd4, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd11) $display("FAIL b2b_first: got pos=%0b rem=%0d expected pos=1 rem=11", posibility, remaining); else passed++;
        drive(1'b1, 2'd0, 3'd4, 8'h00, 4'd15);
        checks++; if (posibility !== 1'b0 || remaining !== 4'd15) $display("FAIL b2b_second: got pos=%0b rem=%0d expected pos=0 rem=15", posibility, remaining); else passed++;
        drive(1'b1, 2'd0, 3'd3, 8'h03, 4'd12);
        checks++; if (posibility !== 1'b1 || remaining !== 4'd0) $display("FAIL b2b_third: got pos=%0b rem=%0d expected pos=1 rem=0", posibility, remaining); else passed++;
        req = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n = 1'b1;
        req = 1'b0; code = 2'd0; count = 3'd0; temp = 8'h00; money = 4'd0;
        @(negedge clk);
        test_reset();
        test_basic_accept();
        test_insufficient_money();
        test_zero_quantity();
        test_hold();
        test_stock_exhaustion();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
